// File: rtl/alu_postprocess.sv
// alu_postprocess: forms the final ALU result and Z/N/C/V flags from the adder
// or logic-unit output, then queues {R, flags} in a 2-entry circular buffer
// with valid/ready handshakes on both the input and output sides.
module alu_postprocess #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] AMod,
  input  logic [WIDTH-1:0] BMod,
  input  logic [WIDTH-1:0] Sum,
  input  logic             Cout,
  input  logic [WIDTH-1:0] LogicRes,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] R,
  output logic             Z,
  output logic             N,
  output logic             C,
  output logic             V
);

  localparam int MSB = WIDTH - 1;

  // One buffered result: the value together with the flags derived from it.
  typedef struct packed {
    logic [WIDTH-1:0] r;
    logic             z;
    logic             n;
    logic             c;
    logic             v;
  } entry_t;

  entry_t     mem [DEPTH];
  entry_t     next_entry;
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       push;
  logic       pop;

  // Select the result and derive the flags for the entry about to be pushed.
  always_comb begin
    // NOTE: a full default before any branch guarantees no field is left
    // unassigned on some path, so no latch can be inferred.
    next_entry = '0;
    if (Op[2]) begin
      // Logic ops never carry or overflow; adder inputs are ignored.
      next_entry.r = LogicRes;
    end else begin
      next_entry.r = Sum;
      next_entry.c = Cout;
      // Signed overflow: operands agree in sign but the sum does not.
      next_entry.v = (AMod[MSB] == BMod[MSB]) && (Sum[MSB] != AMod[MSB]);
    end
    next_entry.z = (next_entry.r == '0);
    next_entry.n = next_entry.r[MSB];
  end

  // Handshake status depends only on the occupancy count.
  assign in_ready  = (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Buffer storage, pointers and occupancy count with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // sees pre-edge values, independent of statement order.
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      // NOTE: storage is cleared on reset because R and the flags are read
      // straight from it and must show zero after reset.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= next_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Head entry drives the outputs directly from storage registers.
  assign R = mem[rd_ptr].r;
  assign Z = mem[rd_ptr].z;
  assign N = mem[rd_ptr].n;
  assign C = mem[rd_ptr].c;
  assign V = mem[rd_ptr].v;

endmodule

// File: tb/tb_alu_postprocess.sv
// Scoreboard bench for alu_postprocess: stimulus pushes expected results into
// a queue on every accepted input; an independent monitor compares the head
// output against that queue whenever the DUT presents a result.
module tb_alu_postprocess;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] Op;
  logic [3:0] AMod, BMod, Sum, LogicRes;
  logic       Cout;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] R;
  logic       Z, N, C, V;

  alu_postprocess #(.WIDTH(4), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .Op(Op), .AMod(AMod), .BMod(BMod), .Sum(Sum), .Cout(Cout),
    .LogicRes(LogicRes), .out_valid(out_valid), .out_ready(out_ready),
    .R(R), .Z(Z), .N(N), .C(C), .V(V)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] r;
    logic       z, n, c, v;
  } exp_t;

  exp_t sb[$];
  exp_t got;
  int   tests = 0;
  int   fails = 0;
  int   pops  = 0;
  bit   mon_en = 1'b0;
  bit   rand_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: result by op class, flags from arithmetic meaning.
  function automatic exp_t model(input logic [2:0] op, input logic [3:0] a, b, s,
                                 input logic co, input logic [3:0] lr);
    exp_t e;
    int   sa, sbv, ssum;
    e = '0;
    if (op[2]) begin
      e.r = lr;
    end else begin
      e.r  = s;
      e.c  = co;
      sa   = int'(a);  if (sa > 7)  sa  -= 16;
      sbv  = int'(b);  if (sbv > 7) sbv -= 16;
      ssum = sa + sbv;
      e.v  = (ssum > 7) || (ssum < -8);
    end
    e.z = (e.r == 4'd0);
    e.n = (e.r >= 4'd8);
    return e;
  endfunction

  // Monitor: compare head against scoreboard; also checks hold while stalled.
  always @(negedge clk) begin
    if (mon_en && out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        got = {R, Z, N, C, V};
        if (out_ready) begin
          check("pop_data", 32'(got), 32'(sb[0]));
          void'(sb.pop_front());
          pops++;
        end else begin
          check("stall_hold", 32'(got), 32'(sb[0]));
        end
      end
    end
  end

  // Present one result; call at posedge+#1, returns at posedge+#1 after the push edge.
  task automatic send(input logic [2:0] op, input logic [3:0] a, b, s,
                      input logic co, input logic [3:0] lr, output int waits);
    bit ok;
    in_valid = 1'b1; Op = op; AMod = a; BMod = b; Sum = s; Cout = co; LogicRes = lr;
    ok = 1'b0;
    waits = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(model(op, a, b, s, co, lr));
        ok = 1'b1;
      end else begin
        waits++;
      end
      @(posedge clk); #1;
    end
    if (!ok) check("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_rand(output int waits);
    logic [3:0] a, b, lr;
    logic [4:0] t;
    logic [2:0] op;
    op = 3'($urandom_range(0, 7));
    a  = 4'($urandom_range(0, 15));
    b  = 4'($urandom_range(0, 15));
    lr = 4'($urandom_range(0, 15));
    t  = {1'b0, a} + {1'b0, b};
    send(op, a, b, t[3:0], t[4], lr, waits);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    Op = 3'($urandom_range(0, 7));
    Sum = 4'($urandom_range(0, 15));
    LogicRes = 4'($urandom_range(0, 15));
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
    check(name, 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_state(input string tag);
    @(negedge clk);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready"},  32'(in_ready),  32'd1);
    check({tag, "_R_flags"},   32'({R, Z, N, C, V}), 32'd0);
  endtask

  initial begin
    int w, p0;
    rst_n = 1'b0; out_ready = 1'b0; AMod = '0; BMod = '0; Cout = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check_reset_state("reset");
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Directed flag cases, each checked one cycle after the push.
    out_ready = 1'b1;
    send(3'b000, 4'b0111, 4'b0001, 4'b1000, 1'b0, 4'b0000, w); idle();
    @(negedge clk);
    check("ovf_add_latency", 32'(out_valid), 32'd1);
    check("ovf_add", 32'({R, Z, N, C, V}), 32'({4'b1000, 1'b0, 1'b1, 1'b0, 1'b1}));
    @(posedge clk); #1;
    send(3'b010, 4'b0001, 4'b1111, 4'b0000, 1'b1, 4'b0110, w); idle();
    @(negedge clk);
    check("neg_zero", 32'({R, Z, N, C, V}), 32'({4'b0000, 1'b1, 1'b0, 1'b1, 1'b0}));
    @(posedge clk); #1;
    send(3'b101, 4'b0111, 4'b0011, 4'b1010, 1'b1, 4'b0000, w); idle();
    @(negedge clk);
    check("logic_zero", 32'({R, Z, N, C, V}), 32'({4'b0000, 1'b1, 1'b0, 1'b0, 1'b0}));
    @(posedge clk); #1;
    drain("drain_directed");

    // Backpressure: third push must be held until the head is popped.
    out_ready = 1'b0;
    p0 = pops;
    send(3'b100, 4'd0, 4'd0, 4'd0, 1'b0, 4'b0001, w);
    send(3'b100, 4'd0, 4'd0, 4'd0, 1'b0, 4'b0010, w);
    check("full_in_ready", 32'(in_ready), 32'd0);
    fork
      begin
        send(3'b100, 4'd0, 4'd0, 4'd0, 1'b0, 4'b0011, w);
        check("third_was_held", 32'(w > 2), 32'd1);
        idle();
      end
      begin
        repeat (3) begin
          @(negedge clk);
          check("held_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    drain("drain_backpressure");
    check("backpressure_pops", 32'(pops - p0), 32'd3);

    // Simultaneous push/pop at count=1, then sustained one-per-cycle flow.
    out_ready = 1'b0;
    send_rand(w);
    out_ready = 1'b1;
    p0 = pops;
    for (int i = 0; i < 20; i++) begin
      send_rand(w);
      check("sustained_no_wait", 32'(w), 32'd0);
    end
    idle();
    drain("drain_sustained");
    check("sustained_pops", 32'(pops - p0), 32'd21);

    // Randomized traffic with random backpressure and gaps.
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          send_rand(w);
          idle();
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1 out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain("drain_random");

    // Reset while full: buffered results discarded, in_valid ignored.
    out_ready = 1'b0;
    send_rand(w);
    send_rand(w);
    check("full_before_reset", 32'(in_ready), 32'd0);
    mon_en = 1'b0;
    rst_n = 1'b0;
    in_valid = 1'b1; Op = 3'b100; LogicRes = 4'b1111;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle();
    sb.delete();
    check_reset_state("midreset");
    mon_en = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    send_rand(w); idle();
    @(negedge clk);
    check("post_reset_latency", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    drain("drain_post_reset");
    @(negedge clk);
    check("final_empty", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_postprocess.md
Name: alu_postprocess

Overview:
- Consumer side of the ALU datapath. Takes the raw adder result produced from the preprocessed operands (AMod/BMod), or the logic-unit result, and forms the final result and the Z/N/C/V flags.
- Results are registered into a 2-entry output buffer with valid/ready handshakes on both sides.
- Sits between the adder/logic unit and the register-file writeback / flag register.

Parameters:
- WIDTH, 4, datapath width of the result and operands
- DEPTH, 2, output buffer entries (fixed at 2; other values unsupported)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous reset, active-low
- in_valid  input  1  upstream presents an ALU result this cycle
- in_ready  output  1  block can accept a result this cycle
- Op  input  3  operation code that produced the result
- AMod  input  WIDTH  first adder operand, after preprocessing
- BMod  input  WIDTH  second adder operand, after preprocessing/complement
- Sum  input  WIDTH  adder sum of AMod+BMod
- Cout  input  1  adder carry out
- LogicRes  input  WIDTH  logic-unit result
- out_valid  output  1  buffered result available
- out_ready  input  1  downstream accepts the head result
- R  output  WIDTH  final result at buffer head
- Z  output  1  zero flag
- N  output  1  negative flag
- C  output  1  carry flag
- V  output  1  overflow flag

Behaviour:
- Interface: one clock (clk). Reset rst_n is synchronous and active-low.
- Op encoding:
  - 000 A+B
  - 001 A+1
  - 010 −A
  - 011 −B
  - 1xx logic op
- Result select:
  - Op[2]=0: R=Sum.
  - Op[2]=1: R=LogicRes.
- Flags, computed combinationally at the input and stored with R:
  - Z = (R==0).
  - N = R[WIDTH-1].
  - Arithmetic (Op[2]=0): C = Cout; V = (AMod[MSB]==BMod[MSB]) & (Sum[MSB]!=AMod[MSB]).
  - Logic (Op[2]=1): C=0, V=0. Cout, AMod and BMod are ignored.
- Handshakes:
  - Push when in_valid & in_ready.
  - Pop when out_valid & out_ready.
  - in_valid and the data inputs are sampled only on push.
  - A result shown on R/flags stays stable while out_valid=1 and out_ready=0.
- Buffer: 2 entries, circular, 1-bit write and read pointers plus a 2-bit count (0..2).
  - in_ready = (count<2).
  - out_valid = (count>0).
  - Outputs come from registers only; no combinational path from inputs to R/flags.
- Latency: a result pushed in cycle t appears on R/flags with out_valid=1 in cycle t+1, provided the buffer was empty.
- Simultaneous push and pop:
  - count=1: both happen, count stays 1, head advances to the new entry.
  - count=2: in_ready=0, so pop only.
  - count=0: push only; there is no same-cycle bypass.
- Ordering: strict FIFO.
- Pointer wrap: pointers toggle 1→0 naturally; count alone distinguishes full from empty.
- Reset (rst_n=0 at a rising edge), including mid-transfer:
  - count=0, both pointers=0, storage cleared to 0.
  - Outputs: out_valid=0, R=0, Z=0, N=0, C=0, V=0, in_ready=1 in the cycle after reset.
  - Any buffered results are discarded.
  - in_valid during reset is ignored.
- in_ready depends only on count, never on in_valid. out_valid never depends on out_ready.

Test Plan:
- Overflowing add: Op=000, AMod=0111, BMod=0001, Sum=1000, Cout=0, out_ready=1 → next cycle R=1000, Z=0, N=1, C=0, V=1.
- Negate zero: Op=010, AMod=0001, BMod=1111, Sum=0000, Cout=1 → R=0000, Z=1, N=0, C=1, V=0.
- Logic op: Op=101, LogicRes=0000, Sum=1010, Cout=1 → R=0000, Z=1, C=0, V=0.
- Backpressure: out_ready=0, three back-to-back pushes (R = 0001, 0010, 0011) → in_ready=0 after the second push, and the third is held upstream. Then out_ready=1 → outputs 0001, 0010, 0011 in order, no loss or duplication, and R stays stable while stalled.
- Simultaneous push/pop at count=1 → count stays 1 and order is preserved. Sustained in_valid=out_ready=1 → one result per cycle after the 1-cycle latency.
- Reset with count=2 → next cycle out_valid=0, in_ready=1, R=0, all flags 0. The first push after reset appears one cycle later.
